// File: rtl/tx_state_ctrl.sv
// Transmit-side state controller: sequences RESET -> INIT -> IDLE/ACTIVE,
// captures threshold configuration in INIT, watches per-channel FIFO flags and
// latches error information until software acknowledges it.
module tx_state_ctrl #(
    parameter int unsigned NCH     = 5,
    parameter int unsigned UW      = 4,
    parameter int unsigned IDLE_TO = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           init,
    input  logic [UW-1:0]  cfg_umbral_mf,
    input  logic [UW-1:0]  cfg_umbral_vc,
    input  logic [UW-1:0]  cfg_umbral_d,
    input  logic [NCH-1:0] fifo_empty,
    input  logic [NCH-1:0] fifo_error,
    input  logic           err_clear,
    output logic [2:0]     state,
    output logic           idle_out,
    output logic           active_out,
    output logic           error_out,
    output logic [UW-1:0]  umbral_mf_out,
    output logic [UW-1:0]  umbral_vc_out,
    output logic [UW-1:0]  umbral_d_out,
    output logic [NCH-1:0] err_chan,
    output logic [7:0]     err_cnt
);

    typedef enum logic [2:0] {
        StReset  = 3'd0,
        StInit   = 3'd1,
        StIdle   = 3'd2,
        StActive = 3'd3,
        StError  = 3'd4
    } state_e;

    localparam logic [7:0] IdleLast = 8'(IDLE_TO - 1);

    state_e         state_q, state_d;
    logic           idle_q, idle_d;
    logic           active_q, active_d;
    logic           error_q, error_d;
    logic [UW-1:0]  mf_q, mf_d;
    logic [UW-1:0]  vc_q, vc_d;
    logic [UW-1:0]  d_q, d_d;
    logic [NCH-1:0] err_chan_q, err_chan_d;
    logic [7:0]     err_cnt_q, err_cnt_d;
    logic [7:0]     idle_cnt_q, idle_cnt_d;

    logic any_err;
    logic all_empty;
    logic [7:0] err_cnt_inc;

    assign any_err     = |fifo_error;
    assign all_empty   = &fifo_empty;
    assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // Next-state, capture and counter logic; flags are derived from the next state
    // so they register alongside it.
    always_comb begin
        state_d    = state_q;
        mf_d       = mf_q;
        vc_d       = vc_q;
        d_d        = d_q;
        err_chan_d = err_chan_q;
        err_cnt_d  = err_cnt_q;
        idle_cnt_d = idle_cnt_q;

        unique case (state_q)
            StReset: begin
                state_d = StInit;
            end
            StInit: begin
                if (init) begin
                    state_d = StIdle;
                end else begin
                    mf_d = cfg_umbral_mf;
                    vc_d = cfg_umbral_vc;
                    d_d  = cfg_umbral_d;
                end
            end
            StIdle: begin
                if (any_err) begin
                    state_d    = StError;
                    err_chan_d = err_chan_q | fifo_error;
                    err_cnt_d  = err_cnt_inc;
                end else if (!all_empty) begin
                    state_d    = StActive;
                    idle_cnt_d = 8'd0;
                end
            end
            StActive: begin
                if (any_err) begin
                    state_d    = StError;
                    err_chan_d = err_chan_q | fifo_error;
                    err_cnt_d  = err_cnt_inc;
                end else if (!all_empty) begin
                    idle_cnt_d = 8'd0;
                end else if (idle_cnt_q == IdleLast) begin
                    // This is the IDLE_TO-th consecutive all-empty cycle.
                    state_d    = StIdle;
                    idle_cnt_d = 8'd0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
            StError: begin
                // Acknowledge wins over errors arriving in the same cycle.
                if (err_clear) begin
                    state_d    = StInit;
                    err_chan_d = '0;
                end else begin
                    err_chan_d = err_chan_q | fifo_error;
                end
            end
            default: begin
                state_d = StReset;
            end
        endcase

        idle_d   = (state_d == StIdle);
        active_d = (state_d == StActive);
        error_d  = (state_d == StError);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StReset;
            idle_q     <= 1'b0;
            active_q   <= 1'b0;
            error_q    <= 1'b0;
            mf_q       <= '0;
            vc_q       <= '0;
            d_q        <= '0;
            err_chan_q <= '0;
            err_cnt_q  <= 8'd0;
            idle_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            idle_q     <= idle_d;
            active_q   <= active_d;
            error_q    <= error_d;
            mf_q       <= mf_d;
            vc_q       <= vc_d;
            d_q        <= d_d;
            err_chan_q <= err_chan_d;
            err_cnt_q  <= err_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign state         = state_q;
    assign idle_out      = idle_q;
    assign active_out    = active_q;
    assign error_out     = error_q;
    assign umbral_mf_out = mf_q;
    assign umbral_vc_out = vc_q;
    assign umbral_d_out  = d_q;
    assign err_chan      = err_chan_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_tx_state_ctrl.sv
// Directed bench for tx_state_ctrl: a vector table for the main sequence plus
// hand-written error-count saturation and mid-ACTIVE reset sequences.
module tb_tx_state_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [3:0] cfg_mf, cfg_vc, cfg_d;
    logic [4:0] fifo_empty, fifo_error;
    logic       err_clear;
    logic [2:0] state;
    logic       idle_out, active_out, error_out;
    logic [3:0] umf, uvc, ud;
    logic [4:0] err_chan;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tx_state_ctrl #(.NCH(5), .UW(4), .IDLE_TO(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .cfg_umbral_mf (cfg_mf),
        .cfg_umbral_vc (cfg_vc),
        .cfg_umbral_d  (cfg_d),
        .fifo_empty    (fifo_empty),
        .fifo_error    (fifo_error),
        .err_clear     (err_clear),
        .state         (state),
        .idle_out      (idle_out),
        .active_out    (active_out),
        .error_out     (error_out),
        .umbral_mf_out (umf),
        .umbral_vc_out (uvc),
        .umbral_d_out  (ud),
        .err_chan      (err_chan),
        .err_cnt       (err_cnt)
    );

    // Packed output view: {state, idle, active, error, mf, vc, d, err_chan, err_cnt}.
    typedef logic [30:0] ovec_t;

    typedef struct {
        logic       rst_n;
        logic       ini;
        logic [3:0] cfg;   // same value driven on all three cfg inputs
        logic [4:0] emp;
        logic [4:0] err;
        logic       clr;
        ovec_t      exp;
    } vec_t;

    function automatic ovec_t ov(input logic [2:0] st, input logic [3:0] m, input logic [3:0] v,
                                 input logic [3:0] d, input logic [4:0] ch,
                                 input logic [7:0] cnt);
        return {st, st == 3'd2, st == 3'd3, st == 3'd4, m, v, d, ch, cnt};
    endfunction

    function automatic vec_t mk(input logic r, input logic i, input logic [3:0] c,
                                input logic [4:0] e, input logic [4:0] er, input logic cl,
                                input ovec_t x);
        vec_t t;
        t.rst_n = r; t.ini = i; t.cfg = c; t.emp = e; t.err = er; t.clr = cl; t.exp = x;
        return t;
    endfunction

    function automatic ovec_t outs();
        return {state, idle_out, active_out, error_out, umf, uvc, ud, err_chan, err_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and settle past the edge.
    task automatic apply(input logic r, input logic i, input logic [3:0] c, input logic [4:0] e,
                         input logic [4:0] er, input logic cl);
        reset = r; init = i; cfg_mf = c; cfg_vc = c; cfg_d = c;
        fifo_empty = e; fifo_error = er; err_clear = cl;
        if (c == 4'd3) begin
            cfg_vc = 4'd5;
            cfg_d  = 4'd7;
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[27];
    logic [7:0] exp_cnt;

    initial begin
        reset = 1'b0; init = 1'b0; cfg_mf = '0; cfg_vc = '0; cfg_d = '0;
        fifo_empty = 5'b11111; fifo_error = '0; err_clear = 1'b0;

        // cfg=3 drives 3/5/7 on mf/vc/d; other values drive the same on all three.
        tbl[0]  = mk(0, 0, 3, 5'b11111, 0, 0, ov(0, 0, 0, 0, 0, 0));
        tbl[1]  = mk(1, 0, 3, 5'b11111, 0, 0, ov(1, 0, 0, 0, 0, 0));
        tbl[2]  = mk(1, 0, 3, 5'b11111, 0, 0, ov(1, 3, 5, 7, 0, 0));
        tbl[3]  = mk(1, 0, 3, 5'b11111, 0, 0, ov(1, 3, 5, 7, 0, 0));
        tbl[4]  = mk(1, 1, 9, 5'b11111, 0, 0, ov(2, 3, 5, 7, 0, 0));
        tbl[5]  = mk(1, 0, 9, 5'b11111, 0, 0, ov(2, 3, 5, 7, 0, 0));
        tbl[6]  = mk(1, 0, 9, 5'b11110, 0, 0, ov(3, 3, 5, 7, 0, 0));
        for (int k = 7; k <= 9; k++) tbl[k] = mk(1, 0, 9, 5'b11111, 0, 0, ov(3, 3, 5, 7, 0, 0));
        tbl[10] = mk(1, 0, 9, 5'b11110, 0, 0, ov(3, 3, 5, 7, 0, 0));
        for (int k = 11; k <= 17; k++) tbl[k] = mk(1, 0, 9, 5'b11111, 0, 0, ov(3, 3, 5, 7, 0, 0));
        tbl[18] = mk(1, 0, 9, 5'b11111, 0, 0, ov(2, 3, 5, 7, 0, 0));
        tbl[19] = mk(1, 0, 9, 5'b11011, 0, 0, ov(3, 3, 5, 7, 0, 0));
        tbl[20] = mk(1, 0, 9, 5'b11111, 5'b00100, 0, ov(4, 3, 5, 7, 5'b00100, 1));
        tbl[21] = mk(1, 0, 9, 5'b11111, 5'b10000, 0, ov(4, 3, 5, 7, 5'b10100, 1));
        tbl[22] = mk(1, 0, 9, 5'b11111, 0, 0, ov(4, 3, 5, 7, 5'b10100, 1));
        tbl[23] = mk(1, 0, 9, 5'b11111, 5'b00001, 1, ov(1, 3, 5, 7, 0, 1));
        tbl[24] = mk(1, 0, 9, 5'b11111, 0, 0, ov(1, 9, 9, 9, 0, 1));
        tbl[25] = mk(1, 1, 4, 5'b11111, 0, 0, ov(2, 9, 9, 9, 0, 1));
        tbl[26] = mk(1, 0, 4, 5'b11110, 5'b00001, 0, ov(4, 9, 9, 9, 5'b00001, 2));

        for (int k = 0; k < 27; k++) begin
            apply(tbl[k].rst_n, tbl[k].ini, tbl[k].cfg, tbl[k].emp, tbl[k].err, tbl[k].clr);
            check($sformatf("vec%0d", k), {1'b0, outs()}, {1'b0, tbl[k].exp});
        end

        // Repeated ERROR entries: count must stop at 255.
        exp_cnt = 8'd2;
        for (int n = 0; n < 260; n++) begin
            apply(1, 0, 4, 5'b11111, 0, 1);
            apply(1, 1, 4, 5'b11111, 0, 0);
            apply(1, 0, 4, 5'b11111, 5'b00010, 0);
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            check("sat_state", {29'd0, state}, 32'd4);
            check("sat_cnt", {24'd0, err_cnt}, {24'd0, exp_cnt});
        end
        check("sat_final", {24'd0, err_cnt}, 32'd255);

        // Reset in the middle of an ACTIVE idle count.
        apply(1, 0, 4, 5'b11111, 0, 1);
        apply(1, 1, 4, 5'b11111, 0, 0);
        apply(1, 0, 4, 5'b01111, 0, 0);
        check("act_entry", {1'b0, outs()}, {1'b0, ov(3, 9, 9, 9, 0, 255)});
        for (int k = 0; k < 4; k++) apply(1, 0, 4, 5'b11111, 0, 0);
        check("act_hold", {29'd0, state}, 32'd3);
        apply(0, 1, 4, 5'b11111, 5'b11111, 1);
        check("mid_reset", {1'b0, outs()}, 32'd0);
        apply(1, 1, 4, 5'b11111, 0, 0);
        check("post_reset", {1'b0, outs()}, {1'b0, ov(1, 0, 0, 0, 0, 0)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
